// File: rtl/lfsr_seq_checker_pkg.sv
// Shared LFSR definitions: word width, seed, recurrence and checker state encodings.
// Both the generator and the checker import this, so the recurrence lives in one place.
package lfsr_seq_checker_pkg;

   localparam int LFSR_W = 3;
   localparam logic [LFSR_W-1:0] LFSR_SEED = 3'b100;

   localparam logic [0:0] ST_SEARCH = 1'b0;
   localparam logic [0:0] ST_LOCKED = 1'b1;

   function automatic logic [LFSR_W-1:0] lfsr3_next(input logic [LFSR_W-1:0] q);
      return {q[0], q[1], q[0] ^ q[2]};
   endfunction

   // 000 and 010 map onto themselves, so a generator stuck there repeats forever
   function automatic logic lfsr3_degenerate(input logic [LFSR_W-1:0] q);
      return (q == 3'b000) || (q == 3'b010);
   endfunction

endpackage

// File: rtl/lfsr_seq_checker_if.sv
// Stream-in / status-out bundle between the LFSR source, the checker and the status block.
interface lfsr_seq_checker_if #(parameter int CNT_W = 16);
   import lfsr_seq_checker_pkg::*;

   logic              in_valid;
   logic [LFSR_W-1:0] in_data;
   logic              clr_cnt;
   logic              locked;
   logic              err_pulse;
   logic [CNT_W-1:0]  err_count;
   logic              stuck;

   modport master (
      output in_valid, in_data, clr_cnt,
      input  locked, err_pulse, err_count, stuck
   );

   modport slave (
      input  in_valid, in_data, clr_cnt,
      output locked, err_pulse, err_count, stuck
   );

endinterface

// File: rtl/lfsr_seq_checker_sat_counter.sv
// Saturating up-counter; clr wins over inc, rst wins over both.
module lfsr_seq_checker_sat_counter #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc,
   input  logic             clr,
   output logic [CNT_W-1:0] count
);

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         count <= '0;
      end else if (inc && (count != {CNT_W{1'b1}})) begin
         count <= count + CNT_W'(1);
      end
   end

endmodule

// File: rtl/lfsr_seq_checker.sv
// Self-synchronising LFSR stream checker: predicts each word from the last one received,
// locks after a run of matches, counts errors while locked and flags degenerate fixed points.
module lfsr_seq_checker
   import lfsr_seq_checker_pkg::*;
#(
   parameter int LOCK_CNT   = 4,
   parameter int UNLOCK_CNT = 3,
   parameter int CNT_W      = 16
) (
   input logic               clk,
   input logic               rst,
   lfsr_seq_checker_if.slave bus
);

   localparam int RUN_MAX = (LOCK_CNT > UNLOCK_CNT) ? LOCK_CNT : UNLOCK_CNT;
   localparam int RUN_W   = $clog2(RUN_MAX + 1);
   localparam logic [RUN_W-1:0] LOCK_LAST   = RUN_W'(LOCK_CNT - 1);
   localparam logic [RUN_W-1:0] UNLOCK_LAST = RUN_W'(UNLOCK_CNT - 1);

   logic [0:0]        state;
   logic              have_prev;
   logic [LFSR_W-1:0] prev_p0;
   logic [RUN_W-1:0]  good_run;
   logic [RUN_W-1:0]  bad_run;
   logic              err_pulse_p1;
   logic              stuck_p1;

   logic              beat;
   logic              match;
   logic              err_inc;

   // Only beats with a predecessor are compared; the first word after reset just seeds prev
   assign beat    = bus.in_valid && have_prev;
   assign match   = (bus.in_data == lfsr3_next(prev_p0)) && !lfsr3_degenerate(bus.in_data);
   assign err_inc = beat && (state == ST_LOCKED) && !match;

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= ST_SEARCH;
         have_prev    <= 1'b0;
         prev_p0      <= '0;
         good_run     <= '0;
         bad_run      <= '0;
         err_pulse_p1 <= 1'b0;
         stuck_p1     <= 1'b0;
      end else begin
         err_pulse_p1 <= 1'b0;
         if (bus.in_valid) begin
            prev_p0   <= bus.in_data;
            have_prev <= 1'b1;
         end
         if (beat) begin
            stuck_p1 <= (bus.in_data == prev_p0) && lfsr3_degenerate(bus.in_data);
            if (state == ST_SEARCH) begin
               if (!match) begin
                  good_run <= '0;
               end else if (good_run == LOCK_LAST) begin
                  state    <= ST_LOCKED;
                  good_run <= '0;
                  bad_run  <= '0;
               end else begin
                  good_run <= good_run + RUN_W'(1);
               end
            end else begin
               if (match) begin
                  bad_run <= '0;
               end else begin
                  err_pulse_p1 <= 1'b1;
                  if (bad_run == UNLOCK_LAST) begin
                     state   <= ST_SEARCH;
                     bad_run <= '0;
                  end else begin
                     bad_run <= bad_run + RUN_W'(1);
                  end
               end
            end
         end
      end
   end

   lfsr_seq_checker_sat_counter #(.CNT_W(CNT_W)) u_err_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (err_inc),
      .clr   (bus.clr_cnt),
      .count (bus.err_count)
   );

   assign bus.locked    = (state == ST_LOCKED);
   assign bus.err_pulse = err_pulse_p1;
   assign bus.stuck     = stuck_p1;

endmodule
